// File: rtl/coax_fire_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coax_fire_ctrl
// Purpose  : Per-channel trigger sequencer for the coax output path. A rising
//            edge on a coax input launches a fixed-width output pulse of
//            firingticks cycles, followed by a dead window of deadticks
//            cycles during which further edges on that channel are ignored.
//            Accepted triggers on the low NHIST channels are counted into
//            saturating histogram bins that can be read back one at a time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_adc     in   1              ADC clock, all logic on its rising edge
//   nrst        in   1              synchronous active-low reset
//   coax_in     in   NCH            trigger inputs (already in clk_adc domain)
//   deadticks   in   8              dead-window length in cycles
//   firingticks in   8              output pulse length in cycles, 0 = off
//   enable      in   1              low blocks acceptance of new triggers
//   resethist   in   1              synchronous clear of all histogram bins
//   hist_sel    in   clog2(NHIST)   histogram bin to read
//   coax_out    out  NCH            registered shaped output pulses
//   busy        out  NCH            channel is firing or in its dead window
//   hist_data   out  CNTW           registered value of the selected bin
// ============================================================================
module coax_fire_ctrl #(
    parameter int NCH   = 16,
    parameter int NHIST = 4,
    parameter int CNTW  = 32
) (
    input  logic                                          clk_adc,
    input  logic                                          nrst,
    input  logic [NCH-1:0]                                coax_in,
    input  logic [7:0]                                    deadticks,
    input  logic [7:0]                                    firingticks,
    input  logic                                          enable,
    input  logic                                          resethist,
    input  logic [((NHIST > 1) ? $clog2(NHIST) : 1)-1:0]  hist_sel,
    output logic [NCH-1:0]                                coax_out,
    output logic [NCH-1:0]                                busy,
    output logic [CNTW-1:0]                               hist_data
);

    localparam int C_HSELW = (NHIST > 1) ? $clog2(NHIST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------------
    state_t          r_state     [NCH];
    logic [7:0]      r_cnt       [NCH];
    logic [7:0]      r_dead_snap [NCH];
    logic [NCH-1:0]  r_prev;

    logic [NCH-1:0]  w_edge;
    logic [NCH-1:0]  w_accept;
    logic            w_fire_ok;

    // Histogram bins
    logic [CNTW-1:0] r_hist [NHIST];

    // ------------------------------------------------------------------------
    // Edge detect and trigger acceptance
    // ------------------------------------------------------------------------
    // r_prev resets to all ones so that an input already high when reset
    // releases is not mistaken for a fresh rising edge.
    assign w_edge    = coax_in & ~r_prev;
    assign w_fire_ok = enable && (firingticks != 8'd0);

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NCH; i++) begin
            w_accept[i] = w_edge[i] && w_fire_ok && (r_state[i] == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Channel sequencers
    // ------------------------------------------------------------------------
    // coax_out and busy are registered alongside the state so that they
    // reflect the state being entered: an edge sampled in cycle t drives
    // coax_out for cycles t+1 .. t+firingticks.
    always_ff @(posedge clk_adc) begin
        if (!nrst) begin
            r_prev   <= '1;
            coax_out <= '0;
            busy     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]     <= ST_IDLE;
                r_cnt[i]       <= 8'd0;
                r_dead_snap[i] <= 8'd0;
            end
        end else begin
            r_prev <= coax_in;
            for (int i = 0; i < NCH; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_accept[i]) begin
                            // Dead length is captured now; firing length is
                            // consumed directly by the down-counter load.
                            r_dead_snap[i] <= deadticks;
                            r_cnt[i]       <= firingticks - 8'd1;
                            r_state[i]     <= ST_FIRE;
                            coax_out[i]    <= 1'b1;
                            busy[i]        <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        if (r_cnt[i] != 8'd0) begin
                            r_cnt[i] <= r_cnt[i] - 8'd1;
                        end else if (r_dead_snap[i] != 8'd0) begin
                            r_cnt[i]    <= r_dead_snap[i] - 8'd1;
                            r_state[i]  <= ST_DEAD;
                            coax_out[i] <= 1'b0;
                        end else begin
                            r_state[i]  <= ST_IDLE;
                            coax_out[i] <= 1'b0;
                            busy[i]     <= 1'b0;
                        end
                    end
                    ST_DEAD: begin
                        // Edges arriving here are dropped, not queued.
                        if (r_cnt[i] != 8'd0) begin
                            r_cnt[i] <= r_cnt[i] - 8'd1;
                        end else begin
                            r_state[i] <= ST_IDLE;
                            busy[i]    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state[i]  <= ST_IDLE;
                        coax_out[i] <= 1'b0;
                        busy[i]     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Histogram bins for the low channels
    // ------------------------------------------------------------------------
    // Clear wins over a same-cycle increment; bins stick at all-ones.
    generate
        for (genvar h = 0; h < NHIST; h++) begin : g_hist
            always_ff @(posedge clk_adc) begin
                if (!nrst) begin
                    r_hist[h] <= '0;
                end else if (resethist) begin
                    r_hist[h] <= '0;
                end else if (w_accept[h] && (r_hist[h] != {CNTW{1'b1}})) begin
                    r_hist[h] <= r_hist[h] + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Readout: samples the bin before this cycle's update lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_adc) begin
        if (!nrst) begin
            hist_data <= '0;
        end else if (32'(hist_sel) < NHIST) begin
            hist_data <= r_hist[hist_sel];
        end else begin
            hist_data <= '0;
        end
    end

    logic w_unused_hsel;
    assign w_unused_hsel = ^{C_HSELW{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_coax_fire_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coax_fire_ctrl
// Purpose  : Self-checking bench for coax_fire_ctrl. Directed scenarios
//            followed by randomized traffic, all compared every cycle against
//            a timeline model (pulse/busy windows as absolute cycle ranges,
//            histogram bins as plain integers). A second instance with 4-bit
//            bins exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coax_fire_ctrl;

    localparam int NCH   = 16;
    localparam int NHIST = 4;

    logic            clk_adc = 1'b0;
    logic            nrst;
    logic [NCH-1:0]  coax_in;
    logic [7:0]      deadticks;
    logic [7:0]      firingticks;
    logic            enable;
    logic            resethist;
    logic [1:0]      hist_sel;

    logic [NCH-1:0]  coax_out, busy;
    logic [31:0]     hist_data;
    logic [NCH-1:0]  coax_out4, busy4;
    logic [3:0]      hist_data4;

    always #5 clk_adc = ~clk_adc;

    coax_fire_ctrl #(.NCH(NCH), .NHIST(NHIST), .CNTW(32)) dut (
        .clk_adc(clk_adc), .nrst(nrst), .coax_in(coax_in),
        .deadticks(deadticks), .firingticks(firingticks), .enable(enable),
        .resethist(resethist), .hist_sel(hist_sel),
        .coax_out(coax_out), .busy(busy), .hist_data(hist_data)
    );

    coax_fire_ctrl #(.NCH(NCH), .NHIST(NHIST), .CNTW(4)) dut4 (
        .clk_adc(clk_adc), .nrst(nrst), .coax_in(coax_in),
        .deadticks(deadticks), .firingticks(firingticks), .enable(enable),
        .resethist(resethist), .hist_sel(hist_sel),
        .coax_out(coax_out4), .busy(busy4), .hist_data(hist_data4)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int              cyc;
    logic [NCH-1:0]  m_prev;
    int              m_start    [NCH];
    int              m_fire_end [NCH];
    int              m_busy_end [NCH];
    longint          m_cnt32    [NHIST];
    longint          m_cnt4     [NHIST];
    longint          exp_hist32;
    longint          exp_hist4;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '1;
        for (int i = 0; i < NCH; i++) begin
            m_start[i]    = -1;
            m_fire_end[i] = -1;
            m_busy_end[i] = -1;
        end
        for (int h = 0; h < NHIST; h++) begin
            m_cnt32[h] = 0;
            m_cnt4[h]  = 0;
        end
        exp_hist32 = 0;
        exp_hist4  = 0;
    endtask

    // Apply the effect of the clock edge numbered cyc to the model.
    task automatic model_edge();
        logic [NCH-1:0] acc;
        acc = '0;
        if (!nrst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            if (coax_in[i] && !m_prev[i] && enable && firingticks != 0 &&
                cyc > m_busy_end[i]) begin
                acc[i]        = 1'b1;
                m_start[i]    = cyc;
                m_fire_end[i] = cyc + int'(firingticks);
                m_busy_end[i] = cyc + int'(firingticks) + int'(deadticks);
            end
        end
        m_prev     = coax_in;
        exp_hist32 = m_cnt32[hist_sel];
        exp_hist4  = m_cnt4[hist_sel];
        for (int h = 0; h < NHIST; h++) begin
            if (resethist) begin
                m_cnt32[h] = 0;
                m_cnt4[h]  = 0;
            end else if (acc[h]) begin
                if (m_cnt32[h] < 64'hFFFF_FFFF) m_cnt32[h]++;
                if (m_cnt4[h] < 15) m_cnt4[h]++;
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++)
            v[i] = (cyc + 1 > m_start[i]) && (cyc + 1 <= m_fire_end[i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++)
            v[i] = (cyc + 1 > m_start[i]) && (cyc + 1 <= m_busy_end[i]);
        return v;
    endfunction

    // One clock: model the edge, let the DUT take it, compare mid-cycle.
    task automatic step();
        logic [NCH-1:0] eo, eb;
        model_edge();
        eo = exp_out();
        eb = exp_busy();
        @(posedge clk_adc);
        @(negedge clk_adc);
        check_val("coax_out",   64'(coax_out),   64'(eo));
        check_val("busy",       64'(busy),       64'(eb));
        check_val("hist_data",  64'(hist_data),  64'(exp_hist32));
        check_val("coax_out4",  64'(coax_out4),  64'(eo));
        check_val("hist_data4", 64'(hist_data4), 64'(exp_hist4));
        cyc++;
    endtask

    task automatic tick(input logic [NCH-1:0] v);
        coax_in = v;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0);
    endtask

    initial begin
        cyc         = 0;
        nrst        = 1'b0;
        coax_in     = 16'h0008;
        deadticks   = 8'd2;
        firingticks = 8'd3;
        enable      = 1'b1;
        resethist   = 1'b0;
        hist_sel    = 2'd0;
        model_reset();

        // Held input across reset release must not fire; re-rise fires once.
        for (int k = 0; k < 3; k++) tick(16'h0008);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) tick(16'h0008);
        tick('0);
        tick(16'h0008);
        idle(8);

        // Basic pulse timing on ch0.
        firingticks = 8'd3; deadticks = 8'd2; hist_sel = 2'd0;
        tick(16'h0001);
        idle(8);

        // Dead-window rejection on ch1: edges at +0, +4, +7.
        firingticks = 8'd2; deadticks = 8'd4; hist_sel = 2'd1;
        tick(16'h0002); idle(3);
        tick(16'h0002); idle(2);
        tick(16'h0002); idle(8);

        // firingticks=0 disables firing.
        firingticks = 8'd0; hist_sel = 2'd2;
        tick(16'h0004); idle(1); tick(16'h0004); idle(3);

        // Single-cycle pulses, no dead time, back-to-back retrigger.
        firingticks = 8'd1; deadticks = 8'd0; hist_sel = 2'd3;
        tick(16'h0008); tick('0); tick(16'h0008); idle(3);

        // Clear coincident with an accepted trigger.
        firingticks = 8'd2; deadticks = 8'd1; hist_sel = 2'd0;
        resethist = 1'b1; tick(16'h0001); resethist = 1'b0;
        idle(5);

        // Reset during FIRE.
        firingticks = 8'd5;
        tick(16'h0001); idle(1);
        nrst = 1'b0; tick('0); nrst = 1'b1;
        idle(3);

        // Gating then all-channel simultaneous triggers.
        firingticks = 8'd2; deadticks = 8'd2;
        enable = 1'b0; tick('1); idle(5);
        enable = 1'b1; tick('1); idle(6);

        // Drive ch0 past the 4-bit bin limit.
        firingticks = 8'd1; deadticks = 8'd0; hist_sel = 2'd0;
        for (int k = 0; k < 20; k++) begin
            tick(16'h0001);
            tick('0);
        end
        idle(2);

        // Randomized traffic, including mid-operation parameter changes.
        for (int k = 0; k < 3000; k++) begin
            coax_in   = 16'($urandom);
            hist_sel  = 2'($urandom);
            enable    = ($urandom_range(0, 15) != 0);
            resethist = ($urandom_range(0, 511) == 0);
            nrst      = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 31) == 0) begin
                firingticks = 8'($urandom_range(0, 5));
                deadticks   = 8'($urandom_range(0, 5));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coax_fire_ctrl.md
Name: coax_fire_ctrl

Overview:
- Per-channel trigger sequencer for the coax output path, clocked on the ADC clock.
- Each coax input rising edge launches a fixed-width output pulse of firingticks cycles, then a dead window of deadticks cycles during which new edges are ignored.
- Accepted triggers on the low channels are counted into readable histogram bins with a synchronous clear.
- Replaces the raw input-to-output passthrough with a scheduled, rate-limited pulse path.

Parameters:
- NCH, 16, number of coax channels.
- NHIST, 4, number of low channels (0..NHIST-1) with trigger counters; must be ≤ NCH.
- CNTW, 32, histogram counter width.

Ports:
- clk_adc, in, 1: single clock; all logic on its rising edge.
- nrst, in, 1: reset, synchronous, active-low.
- coax_in, in, NCH: trigger inputs, already synchronous to clk_adc.
- deadticks, in, 8: dead-window length in cycles.
- firingticks, in, 8: output pulse length in cycles; 0 disables firing.
- enable, in, 1: when low, new triggers are not accepted.
- resethist, in, 1: synchronous clear of all histogram counters.
- hist_sel, in, $clog2(NHIST): index of the counter to read.
- coax_out, out, NCH: registered shaped output pulses.
- busy, out, NCH: channel is in FIRE or DEAD.
- hist_data, out, CNTW: registered value of counter[hist_sel].

Behaviour:
- Reset (nrst=0 at a clock edge):
  - coax_out=0, busy=0, hist_data=0, all counters=0, all channels IDLE.
  - prev register set to all 1s, so an input already high when reset releases does not trigger.
- Edge detect, per channel: edge = coax_in & ~prev. prev <= coax_in every cycle in every state.
- Per-channel FSM, states IDLE, FIRE, DEAD; each channel has its own 8-bit down-counter and snapshot registers.
  - IDLE: if edge && enable && firingticks≠0, then snapshot deadticks, load counter with firingticks-1, go to FIRE. Otherwise stay.
  - FIRE: coax_out=1, busy=1.
    - If counter≠0, decrement.
    - If counter=0 and snapshot dead≠0, load counter with dead-1 and go to DEAD.
    - If counter=0 and dead=0, go to IDLE.
  - DEAD: coax_out=0, busy=1. Edges are ignored and not queued. Decrement counter; at 0 go to IDLE.
- Timing:
  - Edge sampled at cycle t: coax_out is high for exactly cycles t+1 .. t+firingticks.
  - busy is high for t+1 .. t+firingticks+deadticks.
  - With deadticks=0, an edge in cycle t+firingticks+1 retriggers; earlier edges are lost.
- Mid-operation changes:
  - deadticks/firingticks changes during FIRE/DEAD have no effect until the next accepted trigger.
  - enable falling mid-pulse lets in-flight FIRE/DEAD complete normally.
- Histograms, channels < NHIST:
  - counter[i] increments by 1 in the cycle the IDLE→FIRE transition is taken for channel i.
  - Counters saturate at 2^CNTW-1 and do not wrap.
  - resethist=1 clears all counters that cycle and takes priority over a simultaneous increment, so the result is 0.
  - Channels ≥ NHIST are never counted.
- Readout: hist_data <= counter[hist_sel] every cycle, 1-cycle latency. The value read is the pre-update value of that same cycle.
- Channels are fully independent; simultaneous edges on any subset are all accepted.

Test Plan:
- Pulse timing. firingticks=3, deadticks=2; single rising edge on ch0 at cycle 10 → coax_out[0]=1 on cycles 11-13, busy[0]=1 on 11-15. Counter[0]=1 readable via hist_sel=0 at cycle 13.
- Dead-window rejection. firingticks=2, deadticks=4; edges on ch1 at cycles 10, 14, 17 → only the edges at 10 and 17 produce pulses. hist_sel=1 reads 2.
- Zero cases:
  - firingticks=0 with edges on ch2 → coax_out[2] stays 0 and counter[2] stays 0.
  - firingticks=1, deadticks=0 with edges at 10 and 12 → single-cycle pulses at 11 and 13.
- Held input and reset. Hold coax_in[3]=1 across reset release → no pulse. Input falls and rises again → one pulse. Assert nrst=0 during FIRE → coax_out=0 and busy=0 on the next edge.
- Counter priority:
  - resethist=1 in the same cycle as an accepted ch0 trigger → counter[0]=0 afterwards, pulse still fires.
  - Preload a CNTW=4 build to 15, then trigger → counter stays 15.
- Gating and independence:
  - enable=0 with edges on all 16 channels → no pulses.
  - enable=1 with simultaneous edges on all 16 → 16 identical pulses, counters 0-3 each +1, channels 4-15 not counted.
